led_seq_player: RTL and testbench

- Parametrised LED pattern sequencer that steps a synchronous pattern ROM at a programmable rate and drives its output onto an LED bank.
- Successor to the fixed divider, address counter and ROM LED chain, generalised in LED width, pattern depth and step rate.
- Adds run/hold control, four playback modes (loop forward, loop reverse, ping-pong, one-shot) and a runtime-selectable sequence length.
- Sits between the board clock/reset and an external single-port ROM with 1-cycle read latency.

---
 rtl/led_seq_player.sv | 194 +++++++++++++++++++
 tb/tb_led_seq_player.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_player.sv
// rtl/led_seq_player.sv - LED pattern sequencer stepping an external 1-cycle-latency ROM
module led_seq_player #(
    parameter int LED_W   = 8,
    parameter int ADR_W   = 5,
    parameter int DEPTH   = 32,
    parameter int DIV_BY  = 25,
    parameter int SPEED_W = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               run,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    input  logic [ADR_W-1:0]   last_adr,
    output logic [ADR_W-1:0]   rom_adr,
    input  logic [LED_W-1:0]   rom_q,
    output logic [LED_W-1:0]   LED,
    output logic               step,
    output logic               done
);

    // Longest step period (slowest speed); the counter must be able to hold it.
    localparam int MAX_TERM = DIV_BY << ((1 << SPEED_W) - 1);
    localparam int CNT_W    = $clog2(MAX_TERM + 1);

    localparam logic [ADR_W-1:0] TOP_ADR = ADR_W'(DEPTH - 1);
    localparam logic [ADR_W-1:0] ADR_ONE = ADR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term;
    logic [ADR_W-1:0] lim;
    logic [ADR_W-1:0] adr_nx;
    logic             dir_up;
    logic             dir_up_nx;
    logic             tick;
    logic             at_end;
    logic             advance;
    logic             rewind;

    // Step period, clamped sequence end and prescaler terminal detection.
    always_comb begin
        term = CNT_W'(DIV_BY) << speed;
        lim  = (last_adr > TOP_ADR) ? TOP_ADR : last_adr;
        // A count already past a freshly shortened period ticks straight away.
        tick = (state == S_RUN) && run && (cnt >= (term - CNT_ONE));
    end

    // Next address and direction for the selected playback mode.
    always_comb begin
        adr_nx    = rom_adr;
        dir_up_nx = dir_up;
        at_end    = 1'b0;
        case (mode)
            MODE_FWD: begin
                adr_nx = (rom_adr >= lim) ? '0 : rom_adr + ADR_ONE;
            end
            MODE_REV: begin
                adr_nx = ((rom_adr == '0) || (rom_adr > lim)) ? lim : rom_adr - ADR_ONE;
            end
            MODE_PING: begin
                if (lim == '0) begin
                    adr_nx = '0;
                end else if (rom_adr > lim) begin
                    adr_nx = lim;
                end else if (dir_up) begin
                    if (rom_adr == lim) begin
                        dir_up_nx = 1'b0;
                        adr_nx    = lim - ADR_ONE;
                    end else begin
                        adr_nx = rom_adr + ADR_ONE;
                    end
                end else begin
                    if (rom_adr == '0) begin
                        dir_up_nx = 1'b1;
                        adr_nx    = ADR_ONE;
                    end else begin
                        adr_nx = rom_adr - ADR_ONE;
                    end
                end
            end
            default: begin
                // One-shot: the final word stays put and the sequence ends.
                if (rom_adr >= lim) begin
                    at_end = 1'b1;
                end else begin
                    adr_nx = rom_adr + ADR_ONE;
                end
            end
        endcase
    end

    // Playback state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Playback state transitions and the address-update qualifiers.
    always_comb begin
        state_nx = state;
        advance  = tick && !at_end;
        rewind   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_nx = S_HOLD;
                end else if (tick && at_end) begin
                    state_nx = S_DONE;
                end
            end
            S_HOLD: begin
                if (run) begin
                    state_nx = S_RUN;
                end
            end
            default: begin
                if (!run) begin
                    state_nx = S_IDLE;
                    rewind   = 1'b1;
                end
            end
        endcase
    end

    // Prescaler: free-runs only while playing, restarts from zero otherwise.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if ((state == S_RUN) && run && !tick) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= '0;
        end
    end

    // ROM address, ping-pong direction and step pulse.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rom_adr <= '0;
            dir_up  <= 1'b1;
            step    <= 1'b0;
        end else begin
            step <= advance;
            if (advance) begin
                rom_adr <= adr_nx;
                dir_up  <= dir_up_nx;
            end else if (rewind) begin
                rom_adr <= '0;
                dir_up  <= 1'b1;
            end
        end
    end

    // Completion flag mirrors residence in DONE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            done <= 1'b0;
        end else begin
            done <= (state_nx == S_DONE);
        end
    end

    // LED register follows the ROM output every cycle, so a frozen address freezes the LEDs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            LED <= '0;
        end else begin
            LED <= rom_q;
        end
    end

endmodule

// File: tb/tb_led_seq_player.sv
// tb/tb_led_seq_player.sv - scoreboard bench for led_seq_player with a closed-form sequence model
module tb_led_seq_player;

    localparam int LED_W   = 8;
    localparam int ADR_W   = 5;
    localparam int DEPTH   = 20;
    localparam int DIV_BY  = 4;
    localparam int SPEED_W = 2;

    logic               CLK = 1'b0;
    logic               RESET = 1'b0;
    logic               run = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [SPEED_W-1:0] speed = '0;
    logic [ADR_W-1:0]   last_adr = '0;
    logic [ADR_W-1:0]   rom_adr;
    logic [LED_W-1:0]   rom_q = '0;
    logic [LED_W-1:0]   LED;
    logic               step;
    logic               done;

    logic [LED_W-1:0] rom_mem [32];

    typedef struct {
        int kind;
        int addr;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_ref = 0;
    int   led_pend = 0;
    int   led_addr = 0;
    logic done_prev = 1'b0;

    led_seq_player #(
        .LED_W  (LED_W),
        .ADR_W  (ADR_W),
        .DEPTH  (DEPTH),
        .DIV_BY (DIV_BY),
        .SPEED_W(SPEED_W)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .run     (run),
        .mode    (mode),
        .speed   (speed),
        .last_adr(last_adr),
        .rom_adr (rom_adr),
        .rom_q   (rom_q),
        .LED     (LED),
        .step    (step),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        rom_q <= rom_mem[rom_adr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Address after the k-th step of a run started at address 0 with direction up.
    function automatic int exp_addr(input int m, input int lim, input int k);
        int p;
        case (m)
            0: return k % (lim + 1);
            1: return (lim + 1 - (k % (lim + 1))) % (lim + 1);
            2: begin
                if (lim == 0) return 0;
                p = k % (2 * lim);
                return (p <= lim) ? p : 2 * lim - p;
            end
            default: return k;
        endcase
    endfunction

    // Monitor: every step pulse or done rise consumes one scoreboard entry.
    always @(negedge CLK) begin
        if (!RESET) begin
            led_pend = 0;
            done_prev = 1'b0;
        end else begin
            if (led_pend > 0) begin
                led_pend--;
                if (led_pend == 0) check("led_word", LED, rom_mem[led_addr]);
            end
            if (step) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_step: step at rom_adr=%0d, none expected", rom_adr);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_kind_step", 0, mon_e.kind);
                    check("step_addr", rom_adr, mon_e.addr);
                    check("step_gap", cyc - last_ref, mon_e.gap);
                    last_ref = cyc;
                    led_pend = 2;
                    led_addr = mon_e.addr;
                end
            end
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_done: done rose, none expected");
                end else begin
                    mon_e = sb.pop_front();
                    check("event_kind_done", 1, mon_e.kind);
                    check("done_gap", cyc - last_ref, mon_e.gap);
                    last_ref = cyc;
                end
            end
            done_prev = done;
        end
    end

    task automatic wait_drain(input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(posedge CLK);
            c++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d events outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Asynchronous reset between clock edges, then load the controls for the next run.
    task automatic start_seg(input int m, input int sp, input int la);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        run = 1'b0;
        #1;
        check("async_reset_outputs", int'({rom_adr, LED, step, done}), 0);
        sb.delete();
        mode = 2'(m);
        speed = SPEED_W'(sp);
        last_adr = ADR_W'(la);
        @(negedge CLK);
        #1;
    endtask

    task automatic run_seg(input int m, input int sp, input int la, input int n);
        int lim;
        int term;
        lim = (la > DEPTH - 1) ? DEPTH - 1 : la;
        term = DIV_BY << sp;
        start_seg(m, sp, la);
        if (m == 3) begin
            for (int k = 1; k <= lim; k++) sb.push_back('{0, k, (k == 1) ? term + 1 : term});
            sb.push_back('{1, 0, (lim == 0) ? term + 1 : term});
        end else begin
            for (int k = 1; k <= n; k++) sb.push_back('{0, exp_addr(m, lim, k), (k == 1) ? term + 1 : term});
        end
        last_ref = cyc;
        RESET = 1'b1;
        run = 1'b1;
        wait_drain(term * (sb.size() + 2) + 20);
        if (m == 3) begin
            repeat (term) @(negedge CLK);
            check("done_level", done, 1);
            check("done_adr", rom_adr, lim);
            #1;
            run = 1'b0;
            @(negedge CLK);
            check("idle_adr", rom_adr, 0);
            check("idle_done", done, 0);
        end else begin
            repeat (2) @(negedge CLK);
        end
    endtask

    task automatic hold_test();
        int term;
        term = DIV_BY;
        start_seg(0, 0, 5);
        sb.push_back('{0, 1, term + 1});
        sb.push_back('{0, 2, term});
        last_ref = cyc;
        RESET = 1'b1;
        run = 1'b1;
        wait_drain(term * 4 + 20);
        @(negedge CLK);
        #1;
        run = 1'b0;
        repeat (10) @(negedge CLK);
        check("hold_adr", rom_adr, 2);
        check("hold_led", LED, rom_mem[2]);
        #1;
        sb.push_back('{0, 3, term + 1});
        sb.push_back('{0, 4, term});
        sb.push_back('{0, 5, term});
        sb.push_back('{0, 0, term});
        last_ref = cyc;
        run = 1'b1;
        wait_drain(term * 6 + 20);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = LED_W'($urandom);
        repeat (2) @(negedge CLK);
        run_seg(0, 0, 3, 5);
        run_seg(1, 2, 3, 5);
        run_seg(2, 0, 3, 8);
        run_seg(2, 0, 0, 3);
        run_seg(3, 0, 2, 0);
        hold_test();
        run_seg(0, 0, 31, 22);
        run_seg(3, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            run_seg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 31)), int'($urandom_range(1, 12)));
        end
        start_seg(0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
